// File: rtl/mor1kx_tlb_reload_arbiter.sv
// Shares one memory read port between the DMMU and IMMU TLB-reload walkers.
// An owner keeps the port for its whole reload (PTE-pointer beat, then PTE beat).
module mor1kx_tlb_reload_arbiter #(
  parameter int    OPTION_OPERAND_WIDTH = 32,
  parameter string OPTION_ARB_POLICY    = "ROUND_ROBIN"
) (
  input  logic                            clk,
  input  logic                            rst,

  input  logic                            dmmu_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] dmmu_addr_i,
  output logic                            dmmu_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] dmmu_data_o,
  output logic                            dmmu_err_o,

  input  logic                            immu_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] immu_addr_i,
  output logic                            immu_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] immu_data_o,
  output logic                            immu_err_o,

  output logic                            bus_req_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] bus_addr_o,
  input  logic                            bus_ack_i,
  input  logic                            bus_err_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] bus_dat_i,

  output logic [1:0]                      grant_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  localparam logic OWN_DMMU = 1'b0;
  localparam logic OWN_IMMU = 1'b1;

  localparam bit DMMU_FIRST = (OPTION_ARB_POLICY == "DMMU_FIRST");

  logic [1:0]                      state_q, state_d;
  logic                            owner_q, owner_d;
  logic                            last_owner_q, last_owner_d;
  logic                            bus_req_q, bus_req_d;
  logic [OPTION_OPERAND_WIDTH-1:0] bus_addr_q, bus_addr_d;

  logic                            pick_immu;
  logic                            owner_req;
  logic [OPTION_OPERAND_WIDTH-1:0] owner_addr;
  logic                            beat_done;
  logic                            deliver;
  logic                            granted;

  // IMMU wins only if alone, or on a round-robin tie after a DMMU reload.
  assign pick_immu  = immu_req_i &
                      (~dmmu_req_i | (!DMMU_FIRST && (last_owner_q == OWN_DMMU)));
  assign owner_req  = (owner_q == OWN_IMMU) ? immu_req_i  : dmmu_req_i;
  assign owner_addr = (owner_q == OWN_IMMU) ? immu_addr_i : dmmu_addr_i;
  assign beat_done  = bus_ack_i | bus_err_i;
  assign deliver    = (state_q == ST_ACTIVE) && beat_done;
  assign granted    = (state_q == ST_ACTIVE) || (state_q == ST_GAP);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    bus_req_d    = bus_req_q;
    bus_addr_d   = bus_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (dmmu_req_i || immu_req_i) begin
          owner_d    = pick_immu ? OWN_IMMU : OWN_DMMU;
          bus_addr_d = pick_immu ? immu_addr_i : dmmu_addr_i;
          bus_req_d  = 1'b1;
          state_d    = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        // A completion wins over a same-cycle req drop; the ack is still delivered.
        if (beat_done) begin
          bus_req_d = 1'b0;
          state_d   = ST_GAP;
        end else if (!owner_req) begin
          state_d = ST_DRAIN;
        end
      end
      ST_GAP: begin
        if (owner_req) begin
          bus_addr_d = owner_addr;
          bus_req_d  = 1'b1;
          state_d    = ST_ACTIVE;
        end else begin
          last_owner_d = owner_q;
          state_d      = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (beat_done) begin
          bus_req_d    = 1'b0;
          last_owner_d = owner_q;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        bus_req_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_DMMU;
      last_owner_q <= OWN_IMMU;
      bus_req_q    <= 1'b0;
      bus_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      bus_req_q    <= bus_req_d;
      bus_addr_q   <= bus_addr_d;
    end
  end

  assign bus_req_o   = bus_req_q;
  assign bus_addr_o  = bus_addr_q;

  assign dmmu_ack_o  = deliver && (owner_q == OWN_DMMU);
  assign dmmu_err_o  = deliver && (owner_q == OWN_DMMU) && bus_err_i;
  assign dmmu_data_o = bus_dat_i;
  assign immu_ack_o  = deliver && (owner_q == OWN_IMMU);
  assign immu_err_o  = deliver && (owner_q == OWN_IMMU) && bus_err_i;
  assign immu_data_o = bus_dat_i;

  assign grant_o = {granted && (owner_q == OWN_IMMU), granted && (owner_q == OWN_DMMU)};

endmodule

// File: tb/tb_mor1kx_tlb_reload_arbiter.sv
// Directed bench for the TLB-reload arbiter: one round-robin and one DMMU-first instance
// share stimulus; each scenario checks the instance it targets.
module tb_mor1kx_tlb_reload_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        dmmu_req, immu_req;
  logic [31:0] dmmu_addr, immu_addr;
  logic        bus_ack, bus_err;
  logic [31:0] bus_dat;

  logic        r_dack, r_derr, r_iack, r_ierr, r_breq;
  logic [31:0] r_ddat, r_idat, r_baddr;
  logic [1:0]  r_grant;

  logic        f_dack, f_derr, f_iack, f_ierr, f_breq;
  logic [31:0] f_ddat, f_idat, f_baddr;
  logic [1:0]  f_grant;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  mor1kx_tlb_reload_arbiter #(
    .OPTION_OPERAND_WIDTH(32),
    .OPTION_ARB_POLICY("ROUND_ROBIN")
  ) u_rr (
    .clk(clk), .rst(rst),
    .dmmu_req_i(dmmu_req), .dmmu_addr_i(dmmu_addr),
    .dmmu_ack_o(r_dack), .dmmu_data_o(r_ddat), .dmmu_err_o(r_derr),
    .immu_req_i(immu_req), .immu_addr_i(immu_addr),
    .immu_ack_o(r_iack), .immu_data_o(r_idat), .immu_err_o(r_ierr),
    .bus_req_o(r_breq), .bus_addr_o(r_baddr),
    .bus_ack_i(bus_ack), .bus_err_i(bus_err), .bus_dat_i(bus_dat),
    .grant_o(r_grant)
  );

  mor1kx_tlb_reload_arbiter #(
    .OPTION_OPERAND_WIDTH(32),
    .OPTION_ARB_POLICY("DMMU_FIRST")
  ) u_df (
    .clk(clk), .rst(rst),
    .dmmu_req_i(dmmu_req), .dmmu_addr_i(dmmu_addr),
    .dmmu_ack_o(f_dack), .dmmu_data_o(f_ddat), .dmmu_err_o(f_derr),
    .immu_req_i(immu_req), .immu_addr_i(immu_addr),
    .immu_ack_o(f_iack), .immu_data_o(f_idat), .immu_err_o(f_ierr),
    .bus_req_o(f_breq), .bus_addr_o(f_baddr),
    .bus_ack_i(bus_ack), .bus_err_i(bus_err), .bus_dat_i(bus_dat),
    .grant_o(f_grant)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  // Advance one edge; registered outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dmmu_req = 1'b0; immu_req = 1'b0;
    bus_ack = 1'b0; bus_err = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    dmmu_addr = '0; immu_addr = '0; bus_dat = '0;
    do_reset();

    // Reset state
    check("rst_breq",  r_breq,  0);
    check("rst_baddr", r_baddr, 0);
    check("rst_grant", r_grant, 0);
    check("rst_dack",  r_dack,  0);
    check("rst_iack",  r_iack,  0);

    // DMMU alone, two beats
    dmmu_req = 1'b1; dmmu_addr = 32'h1000_0040; #1;
    check("d1_req_lat0", r_breq, 0);
    tick();
    check("d1_breq",  r_breq,  1);
    check("d1_addr",  r_baddr, 32'h1000_0040);
    check("d1_grant", r_grant, 2'b01);
    dmmu_addr = 32'h2000_1ff8;
    tick();
    check("d1_addr_hold", r_baddr, 32'h1000_0040);
    bus_ack = 1'b1; bus_dat = 32'h2000_0001; #1;
    check("d1_ack",  r_dack, 1);
    check("d1_data", r_ddat, 32'h2000_0001);
    check("d1_iack", r_iack, 0);
    check("d1_derr", r_derr, 0);
    tick(); bus_ack = 1'b0;
    check("d1_gap_breq",  r_breq,  0);
    check("d1_gap_grant", r_grant, 2'b01);
    tick();
    check("d2_breq", r_breq,  1);
    check("d2_addr", r_baddr, 32'h2000_1ff8);
    bus_ack = 1'b1; bus_dat = 32'h1234_5401; #1;
    check("d2_ack",  r_dack, 1);
    check("d2_data", r_ddat, 32'h1234_5401);
    check("d2_iack", r_iack, 0);
    tick(); bus_ack = 1'b0; dmmu_req = 1'b0;
    check("d2_gap_breq", r_breq, 0);
    tick();
    check("d2_idle_grant", r_grant, 0);
    bus_ack = 1'b1; #1;
    check("idle_ack_ignored", r_dack, 0);
    tick(); bus_ack = 1'b0;
    check("idle_ack_breq", r_breq, 0);

    // Round-robin ties after reset
    do_reset();
    dmmu_req = 1'b1; immu_req = 1'b1;
    dmmu_addr = 32'h0000_00d0; immu_addr = 32'h0000_00e0;
    tick();
    check("rr1_grant", r_grant, 2'b01);
    check("rr1_addr",  r_baddr, 32'h0000_00d0);
    bus_ack = 1'b1; bus_dat = 32'h0000_0a0a; #1;
    check("rr1_dack", r_dack, 1);
    check("rr1_iack", r_iack, 0);
    tick(); bus_ack = 1'b0; dmmu_req = 1'b0;
    check("rr1_gap_grant", r_grant, 2'b01);
    tick();
    check("rr1_idle_grant", r_grant, 0);
    dmmu_req = 1'b1;
    tick();
    check("rr2_grant", r_grant, 2'b10);
    check("rr2_addr",  r_baddr, 32'h0000_00e0);
    bus_ack = 1'b1; bus_dat = 32'h0000_0b0b; #1;
    check("rr2_iack", r_iack, 1);
    check("rr2_idat", r_idat, 32'h0000_0b0b);
    check("rr2_dack", r_dack, 0);
    tick(); bus_ack = 1'b0; immu_req = 1'b0;
    check("rr2_gap_grant", r_grant, 2'b10);
    tick(); tick();
    check("rr3_grant", r_grant, 2'b01);
    bus_ack = 1'b1; #1;
    tick(); bus_ack = 1'b0; dmmu_req = 1'b0;
    tick();

    // DMMU_FIRST: DMMU re-wins ties, IMMU only when DMMU idle
    do_reset();
    dmmu_req = 1'b1; immu_req = 1'b1;
    tick();
    check("df1_grant", f_grant, 2'b01);
    bus_ack = 1'b1; #1;
    tick(); bus_ack = 1'b0; dmmu_req = 1'b0;
    tick();
    check("df1_idle_grant", f_grant, 0);
    dmmu_req = 1'b1;
    tick();
    check("df2_grant", f_grant, 2'b01);
    check("df2_addr",  f_baddr, 32'h0000_00d0);
    bus_ack = 1'b1; #1;
    tick(); bus_ack = 1'b0; dmmu_req = 1'b0;
    tick(); tick();
    check("df3_grant", f_grant, 2'b10);
    check("df3_addr",  f_baddr, 32'h0000_00e0);
    bus_ack = 1'b1; #1;
    check("df3_iack", f_iack, 1);
    tick(); bus_ack = 1'b0; immu_req = 1'b0;
    tick();

    // Owner drops mid-beat: drain swallows the ack, then IMMU gets the port
    do_reset();
    dmmu_req = 1'b1; immu_req = 1'b1;
    dmmu_addr = 32'h0000_0100; immu_addr = 32'h0000_0200;
    tick();
    check("dr_grant", r_grant, 2'b01);
    dmmu_req = 1'b0;
    tick();
    check("dr_breq_hold", r_breq,  1);
    check("dr_grant0",    r_grant, 0);
    tick(); tick();
    check("dr_breq_hold3", r_breq, 1);
    bus_ack = 1'b1; bus_dat = 32'hdead_beef; #1;
    check("dr_swallow_d", r_dack, 0);
    check("dr_swallow_i", r_iack, 0);
    tick(); bus_ack = 1'b0;
    check("dr_idle_breq",  r_breq,  0);
    check("dr_idle_grant", r_grant, 0);
    tick();
    check("dr_imm_grant", r_grant, 2'b10);
    check("dr_imm_addr",  r_baddr, 32'h0000_0200);

    // Bus error on the IMMU beat
    bus_err = 1'b1; #1;
    check("err_iack", r_iack, 1);
    check("err_ierr", r_ierr, 1);
    check("err_dack", r_dack, 0);
    tick(); bus_err = 1'b0; immu_req = 1'b0;
    check("err_gap_breq",  r_breq,  0);
    check("err_gap_grant", r_grant, 2'b10);
    tick();
    check("err_idle_grant", r_grant, 0);

    // Reset during ACTIVE after a DMMU reload; first tie afterwards goes to DMMU
    dmmu_req = 1'b1;
    tick();
    bus_ack = 1'b1; #1;
    tick(); bus_ack = 1'b0; dmmu_req = 1'b0;
    tick();
    dmmu_req = 1'b1;
    tick();
    check("mr_breq_pre", r_breq, 1);
    rst = 1'b1;
    tick();
    check("mr_breq",  r_breq,  0);
    check("mr_grant", r_grant, 0);
    rst = 1'b0; immu_req = 1'b1;
    tick();
    check("mr_tie_grant", r_grant, 2'b01);
    dmmu_req = 1'b0; immu_req = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1);
  end

endmodule

// File: doc/mor1kx_tlb_reload_arbiter.md
Name: mor1kx_tlb_reload_arbiter

Overview:
- Shares one memory read port between the DMMU and IMMU hardware TLB-reload walkers.
- Grants the port to one walker for its whole multi-beat reload: PTE-pointer fetch, then PTE fetch.
- Registers each beat's address and passes ack/data/error back to the owning walker.
- Sits between both MMUs and the LSU/bus-side reload port; it is only instantiated when hardware TLB reload is enabled.

Parameters:
OPTION_OPERAND_WIDTH, 32, address/data width
OPTION_ARB_POLICY, "ROUND_ROBIN", "ROUND_ROBIN" or "DMMU_FIRST" (DMMU wins every tie)

Ports:
clk  in  1  clock; one clock only
rst  in  1  reset; synchronous, active-high
dmmu_req_i  in  1  DMMU reload request; held high across all beats of one reload
dmmu_addr_i  in  OPTION_OPERAND_WIDTH  DMMU beat address
dmmu_ack_o  out  1  beat complete to DMMU
dmmu_data_o  out  OPTION_OPERAND_WIDTH  read data to DMMU
dmmu_err_o  out  1  bus error on DMMU beat
immu_req_i, immu_addr_i, immu_ack_o, immu_data_o, immu_err_o  same widths and meanings, for the IMMU
bus_req_o  out  1  read request to memory port
bus_addr_o  out  OPTION_OPERAND_WIDTH  registered beat address
bus_ack_i  in  1  read complete
bus_err_i  in  1  read error; terminates the beat like ack
bus_dat_i  in  OPTION_OPERAND_WIDTH  read data
grant_o  out  2  one-hot owner: [0]=DMMU, [1]=IMMU; 0 when idle or draining

Behaviour:
- States: IDLE, ACTIVE, GAP, DRAIN. An owner register (DMMU/IMMU) is valid in ACTIVE and GAP.
- Reset values: state=IDLE, bus_req_o=0, bus_addr_o=0, grant_o=0, last_owner=IMMU (DMMU wins the first tie). All acks/errs=0.

IDLE:
- On a cycle with any req high, pick the owner:
  - only one req high -> that requester;
  - both high, ROUND_ROBIN -> the requester that is not last_owner;
  - both high, DMMU_FIRST -> DMMU.
- At the next edge: capture the owner's addr into bus_addr_o, set bus_req_o=1, go to ACTIVE.
- Latency from req to bus_req_o is 1 cycle.

ACTIVE:
- bus_req_o=1; bus_addr_o is held stable, ignoring requester addr changes.
- If (bus_ack_i|bus_err_i) and the owner's req is high:
  - owner ack_o = bus_ack_i|bus_err_i, combinationally in the same cycle;
  - owner err_o = bus_err_i; owner data_o = bus_dat_i;
  - at the edge: bus_req_o=0, go to GAP.
- Else if the owner's req drops without ack: go to DRAIN; bus_req_o stays 1.
- An ack and a req drop in the same cycle count as a normal completion (the ack is delivered), then GAP.

GAP (1 cycle; lets the walker register its next-beat address):
- bus_req_o=0.
- If the owner's req is high: capture the owner's addr, set bus_req_o=1, go to ACTIVE.
- Else: last_owner=owner, go to IDLE.
- The other requester cannot preempt in GAP.

DRAIN:
- bus_req_o held at 1 until bus_ack_i|bus_err_i; the ack, err and data are swallowed (no requester ack).
- Then bus_req_o=0, last_owner=owner, go to IDLE.
- A bus request is never withdrawn before its ack.

Outputs and timing:
- The non-owner's ack_o/err_o are always 0. data_o equals bus_dat_i for both requesters; it is only meaningful with ack_o.
- bus_ack_i or bus_err_i outside ACTIVE/DRAIN is ignored.
- grant_o is the one-hot owner in ACTIVE and GAP, 0 otherwise.
- Starvation bound under ROUND_ROBIN: a waiting requester is granted within one full reload of the other.

Reset:
- rst mid-reload forces IDLE and bus_req_o=0 at the next edge, regardless of any outstanding beat. The bus side is reset by the same rst.

Decomposition:
- No new shared package; state encodings are module-local localparams (2-bit).
- The policy selection strings sit alongside the existing FEATURE/OPTION string convention in mor1kx-defines.v.
- No sub-module: the arbitration pick is a few gates inside the module.

Test Plan:
- DMMU alone, addrs 0x1000_0040 then 0x2000_1ff8, bus acks with 0x2000_0001 and 0x1234_5401:
  - bus_req_o rises 1 cycle after req;
  - 2 beats carry the correct addrs with a 1-cycle GAP between them;
  - dmmu_ack_o pulses twice with the matching data;
  - immu_ack_o stays 0.
- Both req in the same cycle after reset (ROUND_ROBIN):
  - DMMU is served first (grant_o=01), then IMMU (grant_o=10) with no intervening idle request from DMMU;
  - repeat the tie: IMMU wins, since last_owner=DMMU.
- DMMU_FIRST with both req held continuously: DMMU re-wins every tie; the IMMU is granted only when dmmu_req_i is low in IDLE.
- Owner drops req mid-beat, bus ack 3 cycles later:
  - bus_req_o stays 1 until the ack, the ack is swallowed (dmmu_ack_o=0);
  - then IDLE, and the pending IMMU request is granted the next cycle.
- bus_err_i on the first IMMU beat: immu_ack_o=1 and immu_err_o=1 in the same cycle; the walker drops req; the arbiter returns to IDLE after GAP.
- rst asserted during ACTIVE: bus_req_o=0 and grant_o=0 at the next edge; a fresh request afterwards behaves as after power-on (DMMU wins the first tie).
